raster_addr_gen: RTL and testbench



---
 rtl/raster_addr_gen.sv | 156 +++++++++++++++
 tb/tb_raster_addr_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/raster_addr_gen.sv
// Raster-scan address generator: drives external X/Y coordinate counters and
// turns their counts into a linear base + y*stride + x address stream.
module raster_addr_gen #(
    parameter int CNT_WIDTH  = 9,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  x_last,
    input  logic [CNT_WIDTH-1:0]  y_last,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  x_cnt,
    input  logic [CNT_WIDTH-1:0]  y_cnt,
    output logic                  x_en,
    output logic                  x_sclr,
    output logic                  y_en,
    output logic                  y_sclr,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic                  line_end,
    output logic                  frame_done,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshake: a transfer happens on any edge where addr_valid & addr_ready.
    // Once raised, addr_valid stays high and addr_out/line_end stay frozen
    // until that transfer happens; the consumer may drive addr_ready freely.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CNT_WIDTH-1:0]  x_last_q;
    logic [CNT_WIDTH-1:0]  y_last_q;
    logic [ADDR_WIDTH-1:0] row_base;

    logic                  slot_free;
    logic                  at_x_end;
    logic                  at_y_end;
    logic [CNT_WIDTH:0]    stride;
    logic [ADDR_WIDTH-1:0] stride_ext;
    logic [ADDR_WIDTH-1:0] x_ext;

    logic                  start_acc;
    logic                  load;
    logic                  row_adv;
    logic                  done_evt;

    assign slot_free  = !addr_valid || addr_ready;
    assign at_x_end   = (x_cnt == x_last_q);
    assign at_y_end   = (y_cnt == y_last_q);
    // Stride needs one extra bit so x_last = all-ones does not wrap to zero.
    assign stride     = {1'b0, x_last_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign stride_ext = {{(ADDR_WIDTH-CNT_WIDTH-1){1'b0}}, stride};
    assign x_ext      = {{(ADDR_WIDTH-CNT_WIDTH){1'b0}}, x_cnt};
    assign dbg_state  = state;

    always_comb begin
        state_nx  = state;
        x_en      = 1'b0;
        x_sclr    = 1'b0;
        y_en      = 1'b0;
        y_sclr    = 1'b0;
        start_acc = 1'b0;
        load      = 1'b0;
        row_adv   = 1'b0;
        done_evt  = 1'b0;
        if (rst) begin
            x_sclr   = 1'b1;
            y_sclr   = 1'b1;
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        start_acc = 1'b1;
                        x_sclr    = 1'b1;
                        y_sclr    = 1'b1;
                        state_nx  = RUN;
                    end
                end
                RUN: begin
                    // Counters only move when the current count is consumed
                    // into the output register, so a stall freezes them too.
                    if (slot_free) begin
                        load = 1'b1;
                        if (!at_x_end) begin
                            x_en = 1'b1;
                        end else begin
                            x_sclr  = 1'b1;
                            row_adv = 1'b1;
                            if (at_y_end) begin
                                y_sclr   = 1'b1;
                                state_nx = DRAIN;
                            end else begin
                                y_en = 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (addr_valid && addr_ready) begin
                        done_evt = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x_last_q   <= '0;
            y_last_q   <= '0;
            row_base   <= '0;
            addr_out   <= '0;
            addr_valid <= 1'b0;
            line_end   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= done_evt;
            busy       <= (state_nx != IDLE);

            if (start_acc) begin
                x_last_q <= x_last;
                y_last_q <= y_last;
                row_base <= base_addr;
            end else if (row_adv) begin
                row_base <= row_base + stride_ext;
            end

            if (load) begin
                addr_out   <= row_base + x_ext;
                addr_valid <= 1'b1;
                line_end   <= at_x_end;
            end else if (done_evt) begin
                addr_valid <= 1'b0;
                line_end   <= 1'b0;
            end else if (slot_free) begin
                addr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_raster_addr_gen.sv
// Bench for raster_addr_gen: models the external coordinate counters and
// checks the address stream against a row/column reference list.
module tb_raster_addr_gen;

    localparam int CW = 9;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] x_last_i;
    logic [CW-1:0] y_last_i;
    logic [AW-1:0] base_i;
    logic [CW-1:0] x_cnt = '0;
    logic [CW-1:0] y_cnt = '0;
    logic          x_en, x_sclr, y_en, y_sclr;
    logic [AW-1:0] addr_out;
    logic          addr_valid;
    logic          addr_ready;
    logic          line_end;
    logic          frame_done;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fails  = 0;

    logic [AW:0] exp_q[$];

    raster_addr_gen #(.CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x_last     (x_last_i),
        .y_last     (y_last_i),
        .base_addr  (base_i),
        .x_cnt      (x_cnt),
        .y_cnt      (y_cnt),
        .x_en       (x_en),
        .x_sclr     (x_sclr),
        .y_en       (y_en),
        .y_sclr     (y_sclr),
        .addr_out   (addr_out),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .line_end   (line_end),
        .frame_done (frame_done),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // External coordinate counters: clear has priority over increment.
    always @(posedge clk) begin
        if (x_sclr)    x_cnt <= '0;
        else if (x_en) x_cnt <= x_cnt + 1'b1;
        if (y_sclr)    y_cnt <= '0;
        else if (y_en) y_cnt <= y_cnt + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        n_fails++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    // mode 0: ready high, 1: ready low one cycle in three, 2: random ready.
    task automatic run_frame(input int xl, input int yl, input int base, input int mode,
                             input bit pre_started, input bit mid_start, input bit chain);
        int          c;
        int          n;
        int          t;
        bit          done;
        bit          stalled;
        bit          seen_first;
        logic [AW-1:0] held_a;
        logic        held_le;
        logic [AW:0] e;
        logic [AW-1:0] a;
        exp_q.delete();
        for (int y = 0; y <= yl; y++) begin
            for (int x = 0; x <= xl; x++) begin
                t = (base + y * (xl + 1) + x) % (1 << AW);
                a = t[AW-1:0];
                exp_q.push_back({(x == xl), a});
            end
        end
        n = (xl + 1) * (yl + 1);
        if (!pre_started) begin
            @(negedge clk);
            x_last_i = xl[CW-1:0];
            y_last_i = yl[CW-1:0];
            base_i   = base[AW-1:0];
            start    = 1'b1;
            #1;
            check("start_ctrl", 32'({x_en, x_sclr, y_en, y_sclr}), 32'b0101);
            check("idle_busy", 32'(busy), 0);
        end
        c = 0; done = 0; stalled = 0; seen_first = 0;
        while (!done) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (mid_start && c == 4) start = 1'b1;
            case (mode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = (c % 3 != 0);
                default: addr_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (stalled) begin
                check("stall_addr", 32'(addr_out), 32'(held_a));
                check("stall_le", 32'(line_end), 32'(held_le));
            end
            stalled = 0;
            if (addr_valid && !seen_first) begin
                seen_first = 1;
                check("first_latency", c, 2);
            end
            if (addr_valid) begin
                if (addr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_addr", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("addr", 32'(addr_out), 32'(e[AW-1:0]));
                        check("line_end", 32'(line_end), 32'(e[AW]));
                    end
                end else begin
                    stalled = 1;
                    held_a  = addr_out;
                    held_le = line_end;
                    check("stall_ctrl", 32'({x_en, x_sclr, y_en, y_sclr}), 0);
                end
            end
            if (frame_done) begin
                done = 1;
                check("done_remaining", 32'(exp_q.size()), 0);
                check("done_busy", 32'(busy), 0);
                check("done_valid", 32'(addr_valid), 0);
                check("done_state", 32'(dbg_state), 0);
                if (mode == 0 && !mid_start) check("done_cycle", c, n + 2);
                if (chain) start = 1'b1;
            end else begin
                check("busy_run", 32'(busy), 1);
                if (c > 8 * n + 20) begin
                    fail_now("frame_timeout");
                    done = 1;
                end
            end
        end
        if (!chain) begin
            @(negedge clk);
            #1;
            check("done_pulse", 32'(frame_done), 0);
        end
    endtask

    initial begin
        int   acc;
        logic seen;
        rst        = 1'b1;
        start      = 1'b0;
        addr_ready = 1'b0;
        x_last_i   = '0;
        y_last_i   = '0;
        base_i     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_addr", 32'(addr_out), 0);
        check("rst_valid", 32'(addr_valid), 0);
        check("rst_le", 32'(line_end), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(dbg_state), 0);
        check("rst_ctrl", 32'({x_en, x_sclr, y_en, y_sclr}), 32'b0101);
        rst = 1'b0;

        run_frame(3, 2, 100, 0, 0, 0, 0);
        run_frame(3, 2, 100, 1, 0, 0, 0);
        run_frame(0, 0, 7, 0, 0, 0, 0);
        run_frame(3, 2, 40, 0, 0, 1, 1);
        run_frame(3, 2, 40, 0, 1, 0, 0);
        run_frame(3, 0, 262142, 0, 0, 0, 0);
        repeat (4) begin
            run_frame(int'($urandom_range(0, 9)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 262143)), 2, 0, 0, 0);
        end

        // Reset in the middle of a frame.
        @(negedge clk);
        x_last_i   = 9'd7;
        y_last_i   = 9'd3;
        base_i     = 18'd500;
        start      = 1'b1;
        addr_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 40 && acc < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (addr_valid && addr_ready) acc++;
        end
        check("rst_accepts", acc, 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ctrl", 32'({x_en, x_sclr, y_en, y_sclr}), 32'b0101);
        @(negedge clk);
        #1;
        check("midrst_outs", 32'({addr_out, addr_valid, line_end, frame_done, busy}), 0);
        check("midrst_state", 32'(dbg_state), 0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            #1;
            seen = seen | frame_done;
        end
        check("midrst_no_done", 32'(seen), 0);
        check("midrst_idle_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
